// File: rtl/midi_note_tracker.sv
// midi_note_tracker: turns the raw MIDI byte stream into note events.
// Keeps a table of held notes packed onto note_wire and queues each
// accepted note-on in a small first-word-fall-through FIFO for the
// note memory to consume through a valid/ready handshake.
`timescale 1ns/1ps
module midi_note_tracker #(
   parameter int SLOTS      = 2,
   parameter int NOTE_W     = 8,
   parameter int CHANNEL    = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [7:0]                       rx_byte,
   input  logic                             rx_valid,
   output logic [SLOTS*NOTE_W-1:0]          note_wire,
   output logic [SLOTS-1:0]                 held_mask,
   output logic [NOTE_W-1:0]                evt_note,
   output logic                             evt_valid,
   input  logic                             evt_ready,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]  evt_count,
   output logic                             overflow,
   input  logic                             clear_ovf
);

   localparam int              AW       = $clog2(FIFO_DEPTH);
   localparam int              CW       = $clog2(FIFO_DEPTH+1);
   localparam logic [3:0]      CH_SEL   = 4'(CHANNEL % 16);
   localparam logic [CW-1:0]   FULL_CNT = CW'(FIFO_DEPTH);

   // Running status is implicit: after a complete note message the parser
   // sits in WAIT_D1, after a skipped message it sits in the skip state.
   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_D1,
      S_WAIT_D2,
      S_SKIP1,
      S_SKIP2A,
      S_SKIP2B
   } state_t;

   state_t               r_state;
   logic                 r_kind;      // 1 = 0x9n status, 0 = 0x8n status
   logic [6:0]           r_note;
   logic [NOTE_W-1:0]    r_slot [SLOTS];
   logic [SLOTS-1:0]     r_held;
   logic [NOTE_W-1:0]    r_mem [FIFO_DEPTH];
   logic [AW-1:0]        r_wptr;
   logic [AW-1:0]        r_rptr;
   logic [CW-1:0]        r_count;
   logic                 r_ovf;

   logic [3:0]           w_hi;
   logic                 w_ch_ok;
   logic                 w_vel;
   logic                 w_note_on;
   logic                 w_note_off;
   logic [NOTE_W-1:0]    w_note;
   logic [SLOTS-1:0]     w_match;
   logic [SLOTS-1:0]     w_free;
   logic [SLOTS-1:0]     w_free_oh;
   logic                 w_hit;
   logic                 w_table_full;
   logic                 w_pop;
   logic                 w_push;

   assign w_hi       = rx_byte[7:4];
   assign w_ch_ok    = (CHANNEL == 16) || (rx_byte[3:0] == CH_SEL);
   assign w_vel      = rx_valid && !rx_byte[7] && (r_state == S_WAIT_D2);
   assign w_note_on  = w_vel && r_kind && (rx_byte[6:0] != 7'd0);
   assign w_note_off = w_vel && !(r_kind && (rx_byte[6:0] != 7'd0));
   assign w_note     = NOTE_W'(r_note);

   // Lowest-index empty slot as a one-hot vector (isolate lowest set bit).
   assign w_free       = ~r_held;
   assign w_free_oh    = w_free & (~w_free + SLOTS'(1));
   assign w_table_full = ~|w_free;
   assign w_hit        = |w_match;

   assign evt_valid = (r_count != '0);
   assign w_pop     = evt_valid && evt_ready;
   assign w_push    = w_note_on && ((r_count != FULL_CNT) || w_pop);
   assign evt_note  = evt_valid ? r_mem[r_rptr] : '0;
   assign evt_count = r_count;
   assign overflow  = r_ovf;
   assign held_mask = r_held;

   for (genvar k = 0; k < SLOTS; k++) begin : g_slot
      assign w_match[k] = r_held[k] && (r_slot[k] == w_note);
      assign note_wire[k*NOTE_W +: NOTE_W] = r_slot[k];
   end

   // Byte parser: status decode, channel filter, data byte sequencing.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_kind  <= 1'b0;
         r_note  <= '0;
      end else if (rx_valid) begin
         if (rx_byte[7]) begin
            if (rx_byte >= 8'hF8) begin
               r_state <= r_state;
            end else if (rx_byte >= 8'hF0) begin
               r_state <= S_IDLE;
            end else if (((w_hi == 4'h8) || (w_hi == 4'h9)) && w_ch_ok) begin
               r_kind  <= rx_byte[4];
               r_state <= S_WAIT_D1;
            end else if ((w_hi == 4'hC) || (w_hi == 4'hD)) begin
               r_state <= S_SKIP1;
            end else begin
               r_state <= S_SKIP2A;
            end
         end else begin
            case (r_state)
               S_IDLE:    r_state <= S_IDLE;
               S_WAIT_D1: begin
                  r_note  <= rx_byte[6:0];
                  r_state <= S_WAIT_D2;
               end
               S_WAIT_D2: r_state <= S_WAIT_D1;
               S_SKIP1:   r_state <= S_SKIP1;
               S_SKIP2A:  r_state <= S_SKIP2B;
               S_SKIP2B:  r_state <= S_SKIP2A;
               default:   r_state <= S_IDLE;
            endcase
         end
      end
   end

   // Held-note table: note-off clears matches, new note-on fills lowest free slot.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_held <= '0;
         for (int k = 0; k < SLOTS; k++) r_slot[k] <= '0;
      end else begin
         for (int k = 0; k < SLOTS; k++) begin
            if (w_note_off && w_match[k]) begin
               r_slot[k] <= '0;
               r_held[k] <= 1'b0;
            end else if (w_note_on && !w_hit && w_free_oh[k]) begin
               r_slot[k] <= w_note;
               r_held[k] <= 1'b1;
            end
         end
      end
   end

   // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + AW'(1);
         if (w_pop)  r_rptr <= r_rptr + AW'(1);
         if (w_push && !w_pop)      r_count <= r_count + CW'(1);
         else if (!w_push && w_pop) r_count <= r_count - CW'(1);
      end
   end

   // FIFO storage; contents are don't-care until covered by r_count.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= w_note;
   end

   // Sticky overflow: table full on a new note-on, or a dropped FIFO push.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ovf <= 1'b0;
      end else if ((w_note_on && !w_hit && w_table_full) || (w_note_on && !w_push)) begin
         r_ovf <= 1'b1;
      end else if (clear_ovf) begin
         r_ovf <= 1'b0;
      end
   end

endmodule

// File: doc/midi_note_tracker.md
Name: midi_note_tracker

Overview:
- Parses the raw MIDI byte stream from the keyboard receiver into note events.
- Keeps a parametrised table of currently held notes, packed onto one wide bus for the game/display logic.
- Queues each accepted note-on in a small FIFO for the note memory to consume through a valid/ready handshake.
- Generalises the fixed two-note packed wire and single note-to-memory strobe to N slots, channel filtering, running status and buffered delivery.

Parameters:
- SLOTS, 2, number of held-note slots packed on note_wire (1..8).
- NOTE_W, 8, width of each packed note field; MIDI note is zero-extended (>=7).
- CHANNEL, 16, MIDI channel accepted (0..15); 16 = omni, all channels.
- FIFO_DEPTH, 4, note-on event FIFO depth (power of 2, >=2).

Ports:
- clk, in, 1, system clock.
- reset, in, 1, asynchronous active-low reset.
- rx_byte, in, 8, byte from MIDI UART receiver.
- rx_valid, in, 1, one-cycle strobe; rx_byte is valid.
- note_wire, out, SLOTS*NOTE_W, held notes; slot k at bits [k*NOTE_W +: NOTE_W]; empty slot = 0.
- held_mask, out, SLOTS, bit k=1 when slot k holds a note.
- evt_note, out, NOTE_W, head of event FIFO.
- evt_valid, out, 1, FIFO not empty.
- evt_ready, in, 1, consumer pops when evt_valid & evt_ready.
- evt_count, out, $clog2(FIFO_DEPTH+1), FIFO occupancy.
- overflow, out, 1, sticky: FIFO push dropped or held table full on note-on.
- clear_ovf, in, 1, synchronous clear of overflow (set wins if same cycle).

Behaviour:
- Reset (reset=0, async): parser IDLE, running status cleared, all slots empty, FIFO empty, and all outputs 0.
- Only cycles with rx_valid=1 advance the parser; rx_byte is ignored otherwise.
- Bytes 0xF8–0xFF (realtime): ignored, no state change, running status kept.
- Bytes 0xF0–0xF7: clear running status, go IDLE.
- Status 0x8n/0x9n with channel match (or omni): latch kind, go WAIT_D1.
- Any other channel-voice status, or 0x8n/0x9n on a non-matching channel: go SKIP1 (0xCn, 0xDn) or SKIP2 (others). Running status means "skip"; return to the same skip state after each message.
- Data byte (<0x80) in IDLE: dropped.
- WAIT_D1: latch note, go WAIT_D2.
- WAIT_D2: latch velocity; the event completes and the parser returns to WAIT_D1 (running status).
- A status byte in WAIT_D2 or a SKIP state aborts the partial message and is processed as a new status.
- Event classification: 0x9n with velocity>0 = note-on; 0x8n, or 0x9n with velocity 0 = note-off.
- Note-on update, applied at the clock edge after the velocity byte:
  - If the note is already held, the table is unchanged.
  - Otherwise write it to the lowest-index empty slot.
  - If no slot is empty, the table is unchanged and overflow is set.
- Note-on push: the note is pushed into the FIFO regardless of table state, unless the FIFO is full and no pop happens that cycle. In that case the push is dropped and overflow is set.
- Note-off: clear every slot holding that note (field to 0, mask bit to 0); no FIFO push.
- note_wire and held_mask are registered; 1-cycle latency from the velocity byte.
- FIFO is first-word-fall-through from registers:
  - Pushing into an empty FIFO gives evt_valid=1 and evt_note valid the cycle after the velocity byte.
  - Pop and push in the same cycle are both performed; count is unchanged. This holds when full, i.e. push succeeds.
  - Pop when empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- Reset mid-message discards the partial message; the next data byte without status is dropped.

Test Plan:
- Bytes 0x90,0x2D,0x40 -> one cycle after 0x40: note_wire=16'h002D, held_mask=2'b01, evt_valid=1, evt_note=0x2D; pop with evt_ready -> evt_valid=0.
- Running status: 0x90,0x2D,0x40,0x30,0x40 (0x30 is the next note) -> note_wire=16'h302D, held_mask=2'b11, evt_count=2; then 0x2D,0x00 -> slot0 cleared, note_wire=16'h3000, held_mask=2'b10.
- Full table: SLOTS=2, three distinct note-ons (0x3C, 0x3E, 0x40) -> slots hold 0x3C, 0x3E, overflow=1, evt_count=3; clear_ovf -> overflow=0.
- FIFO full: FIFO_DEPTH=4 and evt_ready=0 with 5 note-ons -> evt_count=4, overflow=1, head=first note. Fifth note-on with evt_ready=1 in the push cycle -> count stays 4, no overflow.
- Filtering: CHANNEL=0, bytes 0x91,0x2D,0x40 then 0xF8 inserted between bytes of 0x90,0x2E,0x40 -> only 0x2E captured; 0xC0,0x05,0x90... -> program change skipped.
- Reset (low) asserted after 0x90,0x2D with 2 notes queued -> all outputs 0 immediately; post-reset 0x40 byte dropped, nothing pushed.
